// File: rtl/sr_frame.sv
// Serial-to-parallel frame receiver: shifts in strobed bits and loads each complete word atomically into a hold register.
// Optional trailing even-parity bit check enabled by defining SR_FRAME_PARITY_EN.
module sr_frame #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH + 2)
) (
    input  logic             serdata_clock,
    input  logic             serdata_reset_n,
    input  logic             serdata,
    input  logic             serdata_enable,
    input  logic             serdata_clear,
    input  logic             output_enable,
    output logic [WIDTH-1:0] parallel_out,
    output logic [CW-1:0]    bit_count,
    output logic             busy,
    output logic             frame_done,
    output logic             parity_error
);

`ifdef SR_FRAME_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif
    localparam logic [CW-1:0] LAST_BIT = CW'(FL - 1);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] hold_q;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s, input logic b);
        if (MSB_FIRST)
            return {s[WIDTH-2:0], b};
        else
            return {b, s[WIDTH-1:1]};
    endfunction

    always_ff @(posedge serdata_clock) begin
        if (!serdata_reset_n) begin
            shift_q    <= '0;
            hold_q     <= '0;
            bit_count  <= '0;
            frame_done <= 1'b0;
`ifdef SR_FRAME_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef SR_FRAME_PARITY_EN
            parity_error <= 1'b0;
`endif
            // Clear outranks a coincident strobe; the hold register is never touched by an abort.
            if (serdata_clear) begin
                shift_q   <= '0;
                bit_count <= '0;
            end else if (serdata_enable) begin
                if (bit_count == LAST_BIT) begin
`ifdef SR_FRAME_PARITY_EN
                    // The trailing bit is parity only; data is already fully shifted in.
                    if (serdata == ^shift_q) begin
                        hold_q     <= shift_q;
                        frame_done <= 1'b1;
                    end else begin
                        parity_error <= 1'b1;
                    end
`else
                    hold_q     <= shift_in(shift_q, serdata);
                    frame_done <= 1'b1;
`endif
                    shift_q   <= '0;
                    bit_count <= '0;
                end else begin
                    shift_q   <= shift_in(shift_q, serdata);
                    bit_count <= bit_count + CW'(1);
                end
            end
        end
    end

`ifndef SR_FRAME_PARITY_EN
    assign parity_error = 1'b0;
`endif

    assign parallel_out = hold_q & {WIDTH{output_enable}};
    assign busy         = (bit_count != '0);

endmodule

// File: tb/tb_sr_frame.sv
// Directed bench for sr_frame: a 16-bit MSB-first instance and an 8-bit LSB-first instance on one clock.
// Parity scenarios run only when SR_FRAME_PARITY_EN is defined.
module tb_sr_frame;

`ifdef SR_FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLA = 16 + PAR;
    localparam int FLB = 8 + PAR;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        oe = 1'b1;
    logic        a_d = 1'b0, a_en = 1'b0, a_clr = 1'b0;
    logic        b_d = 1'b0, b_en = 1'b0, b_clr = 1'b0;
    logic [15:0] a_pout;
    logic [7:0]  b_pout;
    logic [4:0]  a_cnt;
    logic [3:0]  b_cnt;
    logic        a_busy, a_done, a_perr;
    logic        b_busy, b_done, b_perr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_a = 16'h0000;

    always #5 clk = ~clk;

    sr_frame #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_a (
        .serdata_clock(clk), .serdata_reset_n(rst_n), .serdata(a_d),
        .serdata_enable(a_en), .serdata_clear(a_clr), .output_enable(oe),
        .parallel_out(a_pout), .bit_count(a_cnt), .busy(a_busy),
        .frame_done(a_done), .parity_error(a_perr)
    );

    sr_frame #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .serdata_clock(clk), .serdata_reset_n(rst_n), .serdata(b_d),
        .serdata_enable(b_en), .serdata_clear(b_clr), .output_enable(oe),
        .parallel_out(b_pout), .bit_count(b_cnt), .busy(b_busy),
        .frame_done(b_done), .parity_error(b_perr)
    );

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; only the selected instance sees strobe/clear, then sample 1ns after the edge.
    task automatic tick(input bit sel_b, input logic en, input logic d, input logic clr);
        @(negedge clk);
        a_en = !sel_b && en;  a_d = d;  a_clr = !sel_b && clr;
        b_en = sel_b && en;   b_d = d;  b_clr = sel_b && clr;
        @(posedge clk);
        #1;
    endtask

    // Send a 16-bit word MSB-first to instance A, optionally with idle gaps of (i % 6) cycles.
    task automatic send_a(input logic [15:0] w, input bit gaps);
        bit busy_ok = 1'b1;
        for (int i = 0; i < FLA; i++) begin
            logic b;
            b = (i < 16) ? w[15 - i] : ^w;
            if (gaps) begin
                for (int g = 0; g < i % 6; g++) begin
                    tick(1'b0, 1'b0, 1'b0, 1'b0);
                    if (i > 0 && !a_busy) busy_ok = 1'b0;
                end
            end
            if (i == FLA - 1) expect_eq("a_atomic", a_pout, exp_a);
            tick(1'b0, 1'b1, b, 1'b0);
            if (i < FLA - 1 && !a_busy) busy_ok = 1'b0;
        end
        exp_a = w;
        expect_eq("a_busy_during", busy_ok, 1'b1);
        expect_eq("a_word", a_pout, exp_a);
        expect_eq("a_done", a_done, 1'b1);
        expect_eq("a_cnt_end", a_cnt, 0);
        expect_eq("a_busy_end", a_busy, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_eq("a_done_once", a_done, 1'b0);
        expect_eq("a_word_hold", a_pout, exp_a);
    endtask

    // Send 8 data bits LSB-first to instance B, followed by pbit in the parity build.
    task automatic send_b(input logic [7:0] w, input logic pbit);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, w[i], 1'b0);
        if (PAR != 0) tick(1'b1, 1'b1, pbit, 1'b0);
    endtask

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_a_pout", a_pout, 0);
        expect_eq("rst_a_cnt", a_cnt, 0);
        expect_eq("rst_a_busy", a_busy, 0);
        expect_eq("rst_a_done", a_done, 0);
        expect_eq("rst_a_perr", a_perr, 0);
        expect_eq("rst_b_pout", b_pout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Gapless 16-bit frame, then one with strobe gaps
        send_a(16'hA5C3, 1'b0);
        send_a(16'h1234, 1'b1);

        // Abort after 7 bits with clear and enable together
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        expect_eq("abort_cnt_pre", a_cnt, 7);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        expect_eq("abort_cnt", a_cnt, 0);
        expect_eq("abort_done", a_done, 0);
        expect_eq("abort_hold", a_pout, 16'h1234);
        send_a(16'hBEEF, 1'b0);

        // Reset mid-frame after 10 bits
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        a_en = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_eq("midrst_cnt", a_cnt, 0);
        expect_eq("midrst_pout", a_pout, 0);
        expect_eq("midrst_done", a_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_a = 16'h0000;

        // Output gating
        send_a(16'hFFFF, 1'b0);
        @(negedge clk);
        oe = 1'b0;
        #1;
        expect_eq("oe_off", a_pout, 0);
        oe = 1'b1;
        #1;
        expect_eq("oe_on", a_pout, 16'hFFFF);

        // LSB-first 8-bit: first bit lands in bit 0
        send_b(8'h01, 1'b1);
        expect_eq("b_lsb_word", b_pout, 8'h01);
        expect_eq("b_lsb_done", b_done, 1'b1);

        // Back-to-back frames 0x3C then 0xF0 with no idle cycle
        begin
            logic [7:0] words [2];
            int pulses = 0;
            int edge1 = -1;
            int edge2 = -1;
            words[0] = 8'h3C;
            words[1] = 8'hF0;
            for (int k = 0; k < 2 * FLB; k++) begin
                logic [7:0] w;
                int pos;
                logic b;
                w = words[k / FLB];
                pos = k % FLB;
                b = (pos < 8) ? w[pos] : ^w;
                tick(1'b1, 1'b1, b, 1'b0);
                if (b_done) begin
                    pulses++;
                    if (pulses == 1) begin
                        edge1 = k + 1;
                        expect_eq("b2b_word1", b_pout, 8'h3C);
                    end else begin
                        edge2 = k + 1;
                        expect_eq("b2b_word2", b_pout, 8'hF0);
                    end
                end
            end
            expect_eq("b2b_pulses", pulses, 2);
            expect_eq("b2b_edge1", edge1, FLB);
            expect_eq("b2b_edge2", edge2, 2 * FLB);
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            expect_eq("b2b_done_low", b_done, 1'b0);
            expect_eq("b_perr_idle", b_perr, 1'b0);
        end

`ifdef SR_FRAME_PARITY_EN
        // Bad parity: word rejected, hold unchanged, single parity_error pulse
        send_b(8'h07, 1'b0);
        expect_eq("par_bad_hold", b_pout, 8'hF0);
        expect_eq("par_bad_perr", b_perr, 1'b1);
        expect_eq("par_bad_done", b_done, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_eq("par_bad_once", b_perr, 1'b0);
        // Good parity: word loaded
        send_b(8'h07, 1'b1);
        expect_eq("par_ok_word", b_pout, 8'h07);
        expect_eq("par_ok_done", b_done, 1'b1);
        expect_eq("par_ok_perr", b_perr, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_frame.md
# sr_frame

Parametrised serial-to-parallel frame receiver for the divider's control path: shifts in a qualified serial bit stream, counts bits, and transfers each complete WIDTH-bit word atomically into a hold register driving the parallel outputs. Successor to the fixed 16-bit shift register. Adds configurable width and bit order, framing with a completion pulse, abort, and optional parity checking. Downstream divider logic sees only complete, stable words, never a partially shifted value.

## Interface
- WIDTH, 16: data word width, 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
- serdata_clock  in  1  sole clock; all logic on rising edge.
- serdata_reset_n  in  1  reset, synchronous, active-low.
- serdata  in  1  serial data bit.
- serdata_enable  in  1  bit strobe; serdata sampled on an edge where high.
- serdata_clear  in  1  synchronous abort of the in-progress frame; hold register unaffected.
- output_enable  in  1  gates parallel_out (combinational AND).
- parallel_out  out  WIDTH  hold register AND {WIDTH{output_enable}}.
- bit_count  out  CW  bits received in current frame; CW = $clog2(WIDTH+2).
- busy  out  1  high when bit_count != 0.
- frame_done  out  1  one-cycle pulse, new word loaded.
- parity_error  out  1  one-cycle pulse, frame rejected (parity build only).

## Operation
- Frame length FL = WIDTH (FL = WIDTH+1 with parity).
- Reset (serdata_reset_n low at an edge): shift register, hold register and bit_count = 0; frame_done = 0; parity_error = 0. Reset has priority over every other input.
- States, implied by bit_count:
  - IDLE: bit_count = 0.
  - SHIFT: 1 <= bit_count <= FL-1.
- Each enabled bit, not the last of the frame:
  - MSB_FIRST=1: shift = {shift[WIDTH-2:0], serdata}.
  - MSB_FIRST=0: shift = {serdata, shift[WIDTH-1:1]}.
  - bit_count increments.
- Last enabled bit of a frame (bit_count = FL-1): the completed word, including this bit, is loaded into the hold register. bit_count returns to 0; frame_done is set for the next cycle.
- Back-to-back frames: the first bit of the next frame may arrive on the edge immediately after the last bit. No idle cycle is required.
- serdata_clear high: bit_count = 0 and shift = 0. If serdata_enable is also high, clear wins and the bit is discarded. The hold register and any pending frame_done are unchanged.
- serdata_enable low: all state holds. Gaps of any length between bits are legal.
- Deasserting output_enable forces parallel_out to 0 without disturbing the hold register.

## Timing
- Bit capture: rising edge with serdata_enable=1.
- Word latency: hold register (and parallel_out) update on the same edge that captures the last bit. frame_done is high for exactly the following cycle, coincident with the new value.
- Continuous enable: one word every FL cycles, with frame_done high one cycle in FL.
- Reset mid-frame: partial frame lost; the next frame starts from bit_count 0 after reset release.

## Configuration
- SR_FRAME_PARITY_EN defined:
  - The frame carries one extra trailing bit, which is the even-parity bit over the WIDTH data bits. The parity bit does not enter the shift register.
  - Parity match: load the hold register and pulse frame_done.
  - Parity mismatch: hold register unchanged; pulse parity_error instead of frame_done, with the same timing.
- Not defined:
  - FL = WIDTH; no parity logic.
  - parity_error is tied to 0.

## Test plan
- WIDTH=16, MSB_FIRST=1: shift 0xA5C3 MSB-first with continuous enable -> parallel_out = 0xA5C3 on the 16th edge; frame_done high exactly one cycle; bit_count back to 0.
- WIDTH=8, MSB_FIRST=0: shift bits 1,0,0,0,0,0,0,0 -> parallel_out = 0x01. Two back-to-back frames 0x3C, 0xF0 with no gap -> both captured, two frame_done pulses 8 cycles apart.
- Random enable gaps of 0..5 cycles inside a 16-bit frame 0x1234 -> same result as gapless; busy high from the first bit until the last.
- Send 7 bits of a 16-bit frame, assert serdata_clear together with serdata_enable, then send a full 0xBEEF -> parallel_out still shows the previous word until 0xBEEF completes; no frame_done on abort.
- Reset low after 10 bits -> bit_count = 0, parallel_out = 0, frame_done = 0 on the next cycle. Hold output_enable = 0 after loading 0xFFFF -> parallel_out = 0; restore it -> 0xFFFF.
- SR_FRAME_PARITY_EN, WIDTH=8:
  - 0x07 followed by parity bit 1 -> loaded, frame_done.
  - 0x07 followed by parity bit 0 -> hold register unchanged, parity_error pulses once.
